// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it into an 8-entry
// register file with R0 hardwired to zero, and serves bypassed decode reads.

module wb_rf_rdport #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NREGS      = 1 << ADDR_WIDTH
) (
  input  logic [NREGS-1:0][DATA_WIDTH-1:0] regs_i,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic                             commit_i,
  input  logic [ADDR_WIDTH-1:0]            wr_reg_i,
  input  logic [DATA_WIDTH-1:0]            wr_val_i,
  output logic [DATA_WIDTH-1:0]            data_o
);
  always_comb begin
    data_o = regs_i[addr_i];
    if (addr_i == '0)
      data_o = '0;
    else if (commit_i && (addr_i == wr_reg_i))
      data_o = wr_val_i;  // write-through: decode sees this cycle's commit
  end
endmodule

module wb_regfile #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            wb_control_signal,
  input  logic [DATA_WIDTH-1:0] wb_read_data,
  input  logic [DATA_WIDTH-1:0] wb_alu_result,
  input  logic [ADDR_WIDTH-1:0] wb_register_num,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_reg,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic [CNT_WIDTH-1:0]  write_count,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);
  localparam int NREGS  = 1 << ADDR_WIDTH;
  localparam int NPORTS = 2;

  logic [NREGS-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;
  logic [CNT_WIDTH-1:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]             wb_value;
  logic                              commit;
  logic [NPORTS-1:0][ADDR_WIDTH-1:0] rd_addr;
  logic [NPORTS-1:0][DATA_WIDTH-1:0] rd_data;

  assign wb_value = wb_control_signal[0] ? wb_read_data : wb_alu_result;
  assign commit   = wb_control_signal[1] && (wb_register_num != '0);

  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (commit) begin
      regs_d[wb_register_num] = wb_value;
      cnt_d                   = cnt_q + CNT_WIDTH'(1);
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rd_addr = {rd_addr_b, rd_addr_a};

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    wb_rf_rdport #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH),
      .NREGS     (NREGS)
    ) u_rdport (
      .regs_i  (regs_q),
      .addr_i  (rd_addr[p]),
      .commit_i(commit),
      .wr_reg_i(wb_register_num),
      .wr_val_i(wb_value),
      .data_o  (rd_data[p])
    );
  end

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];

  // Raw tap: consumers qualify fwd_reg/fwd_data with fwd_valid.
  assign fwd_valid   = commit;
  assign fwd_reg     = wb_register_num;
  assign fwd_data    = wb_value;
  assign write_count = cnt_q;

  // Debug view is storage only, so it lags a same-cycle commit by one edge.
  assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expecteds are queued from a small
// architectural model or fixed values, then popped against DUT outputs.

module tb_wb_regfile;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] ctrl = 2'b00;
  logic [7:0] rdat = 8'h00, alu = 8'h00;
  logic [2:0] wreg = 3'd0, ra = 3'd0, rb = 3'd0, da = 3'd0;
  logic [7:0] rd_a, rd_b, fdata, dbg, wcnt;
  logic       fvalid;
  logic [2:0] freg;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e;

  logic [7:0] mdl[8];
  logic [7:0] mdl_cnt;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .wb_control_signal(ctrl),
    .wb_read_data(rdat), .wb_alu_result(alu), .wb_register_num(wreg),
    .rd_addr_a(ra), .rd_addr_b(rb), .rd_data_a(rd_a), .rd_data_b(rd_b),
    .fwd_valid(fvalid), .fwd_reg(freg), .fwd_data(fdata),
    .write_count(wcnt), .dbg_addr(da), .dbg_data(dbg)
  );

  task automatic mdl_clear();
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    mdl_cnt = 8'h00;
  endtask

  // One rising edge; the model commits only what the spec says lands.
  task automatic tick();
    logic       c;
    logic [7:0] v;
    c = ctrl[1] && (wreg != 3'd0);
    v = ctrl[0] ? rdat : alu;
    @(posedge clk);
    if (rst_n && c) begin
      mdl[wreg] = v;
      mdl_cnt   = mdl_cnt + 8'd1;
    end
    #2;
  endtask

  task automatic drive(input logic [1:0] c, input logic [2:0] r,
                       input logic [7:0] rd, input logic [7:0] a);
    ctrl = c; wreg = r; rdat = rd; alu = a;
    #1;
  endtask

  task automatic test_reset();
    mdl_clear();
    drive(2'b10, 3'd3, 8'h00, 8'h55);
    da = 3'd3;
    tick(); tick();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total++;
    if ({24'h0, dbg} !== e) begin bad++; $display("FAIL reset_r3_held got=%h exp=%h", dbg, e); end
    e = exp_q.pop_front(); total++;
    if ({24'h0, wcnt} !== e) begin bad++; $display("FAIL reset_cnt_held got=%h exp=%h", wcnt, e); end
    rst_n = 1'b1;
    #1;
    tick();
    drive(2'b00, 3'd0, 8'h00, 8'h00);
    exp_q.push_back(32'h55);
    exp_q.push_back(32'h1);
    e = exp_q.pop_front(); total++;
    if ({24'h0, dbg} !== e) begin bad++; $display("FAIL reset_release_r3 got=%h exp=%h", dbg, e); end
    e = exp_q.pop_front(); total++;
    if ({24'h0, wcnt} !== e) begin bad++; $display("FAIL reset_release_cnt got=%h exp=%h", wcnt, e); end
  endtask

  task automatic test_mux();
    drive(2'b11, 3'd5, 8'hA0, 8'h0F);
    exp_q.push_back(32'hA0);
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h5);
    e = exp_q.pop_front(); total++;
    if ({24'h0, fdata} !== e) begin bad++; $display("FAIL mux_fwd_load got=%h exp=%h", fdata, e); end
    e = exp_q.pop_front(); total++;
    if ({31'h0, fvalid} !== e) begin bad++; $display("FAIL mux_fwd_valid got=%h exp=%h", fvalid, e); end
    e = exp_q.pop_front(); total++;
    if ({29'h0, freg} !== e) begin bad++; $display("FAIL mux_fwd_reg got=%h exp=%h", freg, e); end
    tick();
    drive(2'b10, 3'd6, 8'hA0, 8'h0F);
    tick();
    drive(2'b01, 3'd7, 8'h33, 8'h44);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total++;
    if ({31'h0, fvalid} !== e) begin bad++; $display("FAIL mux_01_fwd_valid got=%h exp=%h", fvalid, e); end
    tick();
    drive(2'b00, 3'd0, 8'h00, 8'h00);
    for (int r = 5; r <= 7; r++) begin
      da = 3'(r);
      #1;
      exp_q.push_back({24'h0, (r == 5) ? 8'hA0 : (r == 6) ? 8'h0F : 8'h00});
      e = exp_q.pop_front(); total++;
      if ({24'h0, dbg} !== e) begin bad++; $display("FAIL mux_dbg_r%0d got=%h exp=%h", r, dbg, e); end
    end
    exp_q.push_back({24'h0, mdl_cnt});
    e = exp_q.pop_front(); total++;
    if ({24'h0, wcnt} !== e) begin bad++; $display("FAIL mux_cnt got=%h exp=%h", wcnt, e); end
  endtask

  task automatic test_bypass();
    drive(2'b10, 3'd2, 8'h00, 8'h11);
    tick();
    ra = 3'd2; rb = 3'd2; da = 3'd2;
    drive(2'b10, 3'd2, 8'h00, 8'h22);
    exp_q.push_back(32'h22);
    exp_q.push_back(32'h22);
    exp_q.push_back(32'h11);
    e = exp_q.pop_front(); total++;
    if ({24'h0, rd_a} !== e) begin bad++; $display("FAIL byp_rd_a got=%h exp=%h", rd_a, e); end
    e = exp_q.pop_front(); total++;
    if ({24'h0, rd_b} !== e) begin bad++; $display("FAIL byp_rd_b got=%h exp=%h", rd_b, e); end
    e = exp_q.pop_front(); total++;
    if ({24'h0, dbg} !== e) begin bad++; $display("FAIL byp_dbg_old got=%h exp=%h", dbg, e); end
    ra = 3'd5;
    #1;
    exp_q.push_back({24'h0, mdl[5]});
    e = exp_q.pop_front(); total++;
    if ({24'h0, rd_a} !== e) begin bad++; $display("FAIL byp_other_reg got=%h exp=%h", rd_a, e); end
    ra = 3'd2;
    tick();
    drive(2'b00, 3'd2, 8'h00, 8'h99);
    exp_q.push_back(32'h22);
    exp_q.push_back(32'h22);
    exp_q.push_back(32'h22);
    e = exp_q.pop_front(); total++;
    if ({24'h0, rd_a} !== e) begin bad++; $display("FAIL byp_after_rd_a got=%h exp=%h", rd_a, e); end
    e = exp_q.pop_front(); total++;
    if ({24'h0, rd_b} !== e) begin bad++; $display("FAIL byp_after_rd_b got=%h exp=%h", rd_b, e); end
    e = exp_q.pop_front(); total++;
    if ({24'h0, dbg} !== e) begin bad++; $display("FAIL byp_after_dbg got=%h exp=%h", dbg, e); end
  endtask

  task automatic test_r0();
    ra = 3'd0; da = 3'd0;
    drive(2'b10, 3'd0, 8'h00, 8'hFF);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total++;
    if ({31'h0, fvalid} !== e) begin bad++; $display("FAIL r0_fwd_valid got=%h exp=%h", fvalid, e); end
    e = exp_q.pop_front(); total++;
    if ({24'h0, rd_a} !== e) begin bad++; $display("FAIL r0_rd_a got=%h exp=%h", rd_a, e); end
    tick();
    drive(2'b00, 3'd0, 8'h00, 8'h00);
    exp_q.push_back({24'h0, mdl_cnt});
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total++;
    if ({24'h0, wcnt} !== e) begin bad++; $display("FAIL r0_cnt got=%h exp=%h", wcnt, e); end
    e = exp_q.pop_front(); total++;
    if ({24'h0, dbg} !== e) begin bad++; $display("FAIL r0_dbg got=%h exp=%h", dbg, e); end
  endtask

  task automatic test_wrap();
    logic [7:0] start;
    // Start from a zero counter so the wrap lands exactly on 0.
    rst_n = 1'b0;
    mdl_clear();
    #1;
    rst_n = 1'b1;
    #1;
    start = mdl_cnt;
    for (int i = 0; i < 256; i++) begin
      drive(2'b10, 3'd1, 8'h00, 8'(i));
      tick();
      if (i == 254) begin
        exp_q.push_back(32'hFF);
        e = exp_q.pop_front(); total++;
        if ({24'h0, wcnt} !== e) begin bad++; $display("FAIL wrap_cnt_ff got=%h exp=%h", wcnt, e); end
      end
    end
    drive(2'b00, 3'd0, 8'h00, 8'h00);
    rb = 3'd1; da = 3'd1;
    #1;
    exp_q.push_back({24'h0, start});
    exp_q.push_back(32'hFF);
    exp_q.push_back({24'h0, mdl[1]});
    e = exp_q.pop_front(); total++;
    if ({24'h0, wcnt} !== e) begin bad++; $display("FAIL wrap_cnt got=%h exp=%h", wcnt, e); end
    e = exp_q.pop_front(); total++;
    if ({24'h0, dbg} !== e) begin bad++; $display("FAIL wrap_r1 got=%h exp=%h", dbg, e); end
    e = exp_q.pop_front(); total++;
    if ({24'h0, rd_b} !== e) begin bad++; $display("FAIL wrap_r1_port_b got=%h exp=%h", rd_b, e); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(2'b10, 3'd4, 8'h00, 8'(8'h40 + i));
      tick();
    end
    drive(2'b10, 3'd4, 8'h00, 8'hEE);
    ra = 3'd4; rb = 3'd3; da = 3'd4;
    #1;
    rst_n = 1'b0;
    mdl_clear();
    #1;
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'hEE);
    e = exp_q.pop_front(); total++;
    if ({24'h0, dbg} !== e) begin bad++; $display("FAIL arst_r4_now got=%h exp=%h", dbg, e); end
    e = exp_q.pop_front(); total++;
    if ({24'h0, wcnt} !== e) begin bad++; $display("FAIL arst_cnt_now got=%h exp=%h", wcnt, e); end
    e = exp_q.pop_front(); total++;
    if ({24'h0, rd_b} !== e) begin bad++; $display("FAIL arst_r3_now got=%h exp=%h", rd_b, e); end
    e = exp_q.pop_front(); total++;
    if ({24'h0, rd_a} !== e) begin bad++; $display("FAIL arst_bypass got=%h exp=%h", rd_a, e); end
    tick();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); total++;
    if ({24'h0, dbg} !== e) begin bad++; $display("FAIL arst_edge_r4 got=%h exp=%h", dbg, e); end
    e = exp_q.pop_front(); total++;
    if ({24'h0, wcnt} !== e) begin bad++; $display("FAIL arst_edge_cnt got=%h exp=%h", wcnt, e); end
    rst_n = 1'b1;
    drive(2'b11, 3'd4, 8'h77, 8'h00);
    tick();
    drive(2'b00, 3'd0, 8'h00, 8'h00);
    exp_q.push_back(32'h77);
    exp_q.push_back(32'h1);
    e = exp_q.pop_front(); total++;
    if ({24'h0, dbg} !== e) begin bad++; $display("FAIL arst_resume_r4 got=%h exp=%h", dbg, e); end
    e = exp_q.pop_front(); total++;
    if ({24'h0, wcnt} !== e) begin bad++; $display("FAIL arst_resume_cnt got=%h exp=%h", wcnt, e); end
  endtask

  initial begin
    test_reset();
    test_mux();
    test_bypass();
    test_r0();
    test_wrap();
    test_async_reset();
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
